// File: rtl/pkt_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_stream_arbiter_pkg
//  Description : Shared definitions for the packet stream arbiter slice.
//                - arb_state_t : two-state arbiter FSM encoding
//                                (ST_IDLE = 1'b0, ST_BUSY = 1'b1)
//                - idx_w()     : width of a port index for a given port count
//  Revision    : 1.0  initial release
// ============================================================================
package pkt_stream_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // A single port still needs a one-bit index so vectors never collapse to [-1:0].
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_stream_arbiter_if
//  Description : Bundle of N_PORTS upstream AXI-Stream ports plus the single
//                downstream stream towards the packet processor.
//                Modports:
//                  master : arbiter side (drives s_tready and all m_* except m_tready)
//                  slave  : environment side (drives s_tvalid/tdata/tlast/meta, m_tready)
//                Signals:
//                  s_tvalid/s_tlast [N_PORTS], s_tdata [N_PORTS*DATA_W],
//                  s_meta [N_PORTS*META_W], s_tready [N_PORTS],
//                  m_tvalid, m_tdata, m_tlast, m_tready, m_meta, m_meta_valid,
//                  m_port [idx_w(N_PORTS)],
//                  pkt_cnt [N_PORTS*CNT_W] (only with PKT_STATS_EN defined)
//  Revision    : 1.0  initial release
// ============================================================================
interface pkt_stream_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 64,
    parameter int META_W  = 32
`ifdef PKT_STATS_EN
  , parameter int CNT_W   = 32
`endif
) ();
    import pkt_stream_arbiter_pkg::*;

    localparam int c_IDX_W = idx_w(N_PORTS);

    logic [N_PORTS-1:0]        s_tvalid;
    logic [N_PORTS*DATA_W-1:0] s_tdata;
    logic [N_PORTS-1:0]        s_tlast;
    logic [N_PORTS*META_W-1:0] s_meta;
    logic [N_PORTS-1:0]        s_tready;

    logic                      m_tvalid;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tlast;
    logic                      m_tready;
    logic [META_W-1:0]         m_meta;
    logic                      m_meta_valid;
    logic [c_IDX_W-1:0]        m_port;
`ifdef PKT_STATS_EN
    logic [N_PORTS*CNT_W-1:0]  pkt_cnt;
`endif

    modport master (
        input  s_tvalid, s_tdata, s_tlast, s_meta, m_tready,
`ifdef PKT_STATS_EN
        output pkt_cnt,
`endif
        output s_tready, m_tvalid, m_tdata, m_tlast, m_meta, m_meta_valid, m_port
    );

    modport slave (
        output s_tvalid, s_tdata, s_tlast, s_meta, m_tready,
`ifdef PKT_STATS_EN
        input  pkt_cnt,
`endif
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_meta, m_meta_valid, m_port
    );

endinterface
`default_nettype wire

// File: rtl/pkt_stream_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority encoder. Scans
//                last_g+1, last_g+2, ... modulo N_PORTS and returns the first
//                asserted request. last_g itself has the lowest priority.
//  Ports       : req    [N_PORTS] in  request vector
//                last_g [IDX]     in  previously served index
//                any              out at least one request asserted
//                sel    [IDX]     out selected index (0 when any=0)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import pkt_stream_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]          req,
    input  logic [idx_w(N_PORTS)-1:0]   last_g,
    output logic                        any,
    output logic [idx_w(N_PORTS)-1:0]   sel
);

    localparam int c_IDX_W = idx_w(N_PORTS);

    // One extra bit so last_g + offset never overflows before the wrap.
    logic [c_IDX_W:0] w_pos;

    // Offsets are visited from farthest to nearest so the nearest requester
    // after last_g is the final (winning) assignment.
    always_comb begin
        any   = 1'b0;
        sel   = '0;
        w_pos = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            w_pos = {1'b0, last_g} + (c_IDX_W+1)'(k);
            if (w_pos >= (c_IDX_W+1)'(N_PORTS)) begin
                w_pos = w_pos - (c_IDX_W+1)'(N_PORTS);
            end
            for (int p = 0; p < N_PORTS; p++) begin
                if (req[p] && (w_pos == (c_IDX_W+1)'(p))) begin
                    any = 1'b1;
                    sel = c_IDX_W'(p);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_stream_arbiter
//  Description : Packet-level round-robin arbiter sharing one AXI-Stream
//                output between N_PORTS sources. A grant is held from the
//                first beat to the tlast beat, so packets never interleave.
//                m_meta_valid pulses on each packet's first handshake.
//  Ports       : clk, rst (synchronous, active-high)
//                bus : pkt_stream_arbiter_if.master (see interface header)
//  Config      : PKT_STATS_EN - when defined, per-port CNT_W packet counters
//                on bus.pkt_cnt, wrapping, cleared only by rst.
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_stream_arbiter
    import pkt_stream_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 64,
    parameter int META_W  = 32
`ifdef PKT_STATS_EN
  , parameter int CNT_W   = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    pkt_stream_arbiter_if.master bus
);

    localparam int c_IDX_W = idx_w(N_PORTS);

    arb_state_t          r_state;
    logic [c_IDX_W-1:0]  r_grant;
    logic [c_IDX_W-1:0]  r_last_g;
    logic                r_sop;

    logic                w_any;
    logic [c_IDX_W-1:0]  w_sel;
    logic                w_tvalid;
    logic [DATA_W-1:0]   w_tdata;
    logic                w_tlast;
    logic [META_W-1:0]   w_meta;
    logic [N_PORTS-1:0]  w_s_tready;
    logic                w_hs;
    logic                w_eop;

    rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_rr_pick (
        .req    (bus.s_tvalid),
        .last_g (r_last_g),
        .any    (w_any),
        .sel    (w_sel)
    );

    // Granted-port passthrough; everything reads as zero while idle.
    always_comb begin
        w_tvalid   = 1'b0;
        w_tdata    = '0;
        w_tlast    = 1'b0;
        w_meta     = '0;
        w_s_tready = '0;
        if (r_state == ST_BUSY) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (r_grant == c_IDX_W'(i)) begin
                    w_tvalid      = bus.s_tvalid[i];
                    w_tdata       = bus.s_tdata[i*DATA_W +: DATA_W];
                    w_tlast       = bus.s_tlast[i];
                    w_meta        = bus.s_meta[i*META_W +: META_W];
                    w_s_tready[i] = bus.m_tready;
                end
            end
        end
    end

    assign w_hs  = w_tvalid & bus.m_tready;
    assign w_eop = w_hs & w_tlast;

    assign bus.m_tvalid     = w_tvalid;
    assign bus.m_tdata      = w_tdata;
    assign bus.m_tlast      = w_tlast;
    assign bus.m_meta       = w_meta;
    assign bus.s_tready     = w_s_tready;
    assign bus.m_meta_valid = r_sop & w_hs;
    assign bus.m_port       = r_grant;

    // Arbitration takes the idle cycle; r_grant is kept after the packet so
    // m_port still reports the last winner while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_last_g <= c_IDX_W'(N_PORTS - 1);
            r_sop    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_sop   <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_hs) begin
                        r_sop <= 1'b0;
                    end
                    if (w_eop) begin
                        r_last_g <= r_grant;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PKT_STATS_EN
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_pkt_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_eop && (r_grant == c_IDX_W'(gi))) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign bus.pkt_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_stream_arbiter
//  Description : Self-checking bench for pkt_stream_arbiter. Sources are
//                packet queues per port; a transaction-level reference model
//                (current owner, last winner, beats sent) predicts every
//                output each cycle. Directed table rows, hand-written corner
//                sequences and a randomized phase. Counter checks are built
//                only with PKT_STATS_EN defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pkt_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MW = 8;
`ifdef PKT_STATS_EN
    localparam int CW = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pkt_stream_arbiter_if #(.N_PORTS(N), .DATA_W(DW), .META_W(MW)
`ifdef PKT_STATS_EN
      , .CNT_W(CW)
`endif
    ) bus ();

    pkt_stream_arbiter #(.N_PORTS(N), .DATA_W(DW), .META_W(MW)
`ifdef PKT_STATS_EN
      , .CNT_W(CW)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PKT_STATS_EN
    // Second instance with 2-bit counters sees identical stimulus.
    pkt_stream_arbiter_if #(.N_PORTS(N), .DATA_W(DW), .META_W(MW), .CNT_W(2)) bus2 ();
    assign bus2.s_tvalid = bus.s_tvalid;
    assign bus2.s_tdata  = bus.s_tdata;
    assign bus2.s_tlast  = bus.s_tlast;
    assign bus2.s_meta   = bus.s_meta;
    assign bus2.m_tready = bus.m_tready;
    pkt_stream_arbiter #(.N_PORTS(N), .DATA_W(DW), .META_W(MW), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- sources ----------------
    int pend_len [N][32];
    int p_head [N];
    int p_tail [N];
    int p_beat [N];
    int p_pkt  [N];
    bit p_gap  [N];
    bit gap_en      = 1'b0;
    int tready_mode = 0;     // 0: always ready, 1: manual, 2: random

    // ---------------- reference model ----------------
    bit m_known   = 1'b0;
    int mo_owner  = -1;
    int mo_last   = N - 1;
    int mo_port   = 0;
    int mo_beats  = 0;
    int mo_cnt [N];
    int done_q[$];
    int dut_mv    = 0;
    int dut_beats = 0;

    // ---------------- samples ----------------
    logic          s_tv, s_tl, s_mv;
    logic [DW-1:0] s_data;
    logic [MW-1:0] s_meta;
    logic [N-1:0]  s_sready;
    logic [1:0]    s_port;

    typedef struct {
        logic [N-1:0] mask;
        int           len;
        int           rounds;
        int           n_exp;
        int           order [8];
    } row_t;
    row_t rows [5];

    function automatic bit has(input int p);
        return p_head[p] != p_tail[p];
    endfunction

    function automatic int pending(input int p);
        return (p_tail[p] - p_head[p] + 32) % 32;
    endfunction

    function automatic bit src_valid(input int p);
        return has(p) && !(p_gap[p] && p_beat[p] == 0);
    endfunction

    function automatic bit src_last(input int p);
        return has(p) && (p_beat[p] == pend_len[p][p_head[p]] - 1);
    endfunction

    function automatic logic [DW-1:0] src_data(input int p);
        int pk, bt;
        pk = p_pkt[p];
        bt = p_beat[p];
        return has(p) ? {p[3:0], pk[5:0], bt[5:0]} : '0;
    endfunction

    function automatic logic [MW-1:0] src_meta(input int p);
        int pk;
        pk = p_pkt[p];
        return has(p) ? {p[3:0], pk[3:0]} : '0;
    endfunction

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int rr_model(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int p = 0; p < N; p++) if (has(p)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int p, input int len);
        pend_len[p][p_tail[p]] = len;
        p_tail[p] = (p_tail[p] + 1) % 32;
    endtask

    task automatic flush();
        for (int p = 0; p < N; p++) begin
            p_head[p] = 0;
            p_tail[p] = 0;
            p_beat[p] = 0;
            p_gap[p]  = 1'b0;
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            bus.s_tvalid[p]          = src_valid(p);
            bus.s_tlast[p]           = src_last(p);
            bus.s_tdata[p*DW +: DW]  = src_data(p);
            bus.s_meta[p*MW +: MW]   = src_meta(p);
        end
        if (tready_mode == 0) bus.m_tready = 1'b1;
        else if (tready_mode == 2) bus.m_tready = ($urandom % 4) != 0;
    endtask

    task automatic cycle();
        logic [N-1:0]  req, exp_rdy, hs;
        logic          exp_tv, exp_tl, exp_mv;
        logic [DW-1:0] exp_d;
        logic [MW-1:0] exp_m;
        int            w;
`ifdef PKT_STATS_EN
        logic [N*CW-1:0] exp_cnt;
        logic [N*2-1:0]  exp_cnt2;
`endif
        drive();
        @(negedge clk);
        s_tv     = bus.m_tvalid;
        s_tl     = bus.m_tlast;
        s_mv     = bus.m_meta_valid;
        s_data   = bus.m_tdata;
        s_meta   = bus.m_meta;
        s_sready = bus.s_tready;
        s_port   = bus.m_port;
        for (int p = 0; p < N; p++) req[p] = src_valid(p);
        exp_rdy = '0;
        exp_tv  = 1'b0;
        exp_tl  = 1'b0;
        exp_d   = '0;
        exp_m   = '0;
        if (mo_owner >= 0) begin
            exp_tv            = req[mo_owner];
            exp_tl            = src_last(mo_owner);
            exp_d             = src_data(mo_owner);
            exp_m             = src_meta(mo_owner);
            exp_rdy[mo_owner] = bus.m_tready;
        end
        exp_mv = (mo_owner >= 0) && (mo_beats == 0) && exp_tv && bus.m_tready;
        if (m_known) begin
            chk("m_tvalid", s_tv, exp_tv);
            chk("m_tlast", s_tl, exp_tl);
            chk("m_tdata", s_data, exp_d);
            chk("m_meta", s_meta, exp_m);
            chk("m_meta_valid", s_mv, exp_mv);
            chk("s_tready", s_sready, exp_rdy);
            chk("m_port", s_port, mo_port);
`ifdef PKT_STATS_EN
            for (int p = 0; p < N; p++) begin
                exp_cnt[p*CW +: CW] = CW'(mo_cnt[p]);
                exp_cnt2[p*2 +: 2]  = 2'(mo_cnt[p]);
            end
            chk("pkt_cnt", bus.pkt_cnt, exp_cnt);
            chk("pkt_cnt_w2", bus2.pkt_cnt, exp_cnt2);
`endif
        end
        if (s_mv) dut_mv++;
        if (s_tv && bus.m_tready) dut_beats++;
        hs = req & exp_rdy;
        if (rst) begin
            m_known  = 1'b1;
            mo_owner = -1;
            mo_last  = N - 1;
            mo_port  = 0;
            mo_beats = 0;
            for (int p = 0; p < N; p++) mo_cnt[p] = 0;
        end else if (mo_owner < 0) begin
            w = rr_model(req, mo_last);
            if (w >= 0) begin
                mo_owner = w;
                mo_port  = w;
                mo_beats = 0;
            end
        end else if (exp_tv && bus.m_tready) begin
            mo_beats++;
            if (exp_tl) begin
                mo_cnt[mo_owner]++;
                done_q.push_back(mo_owner);
                mo_last  = mo_owner;
                mo_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (hs[p]) begin
                p_beat[p]++;
                if (p_beat[p] == pend_len[p][p_head[p]]) begin
                    p_beat[p] = 0;
                    p_head[p] = (p_head[p] + 1) % 32;
                    p_pkt[p]++;
                end
            end
            p_gap[p] = gap_en && (p_beat[p] == 0) && (($urandom % 4) == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        cycle();
        cycle();
        rst = 1'b0;
        done_q.delete();
    endtask

    task automatic run_until_done(input int bound, output int ncyc);
        ncyc = 0;
        while ((any_pending() || mo_owner >= 0) && ncyc < bound) begin
            cycle();
            ncyc++;
        end
        if (any_pending() || mo_owner >= 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: work still pending after %0d cycles, required done", bound);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, b0, m0;
        logic [DW-1:0] prev_d;
        logic [MW-1:0] prev_m;

        rows[0] = '{4'b0100, 3, 1, 1, '{2, 0, 0, 0, 0, 0, 0, 0}};
        rows[1] = '{4'b1011, 2, 2, 6, '{0, 1, 3, 0, 1, 3, 0, 0}};
        rows[2] = '{4'b1111, 1, 2, 8, '{0, 1, 2, 3, 0, 1, 2, 3}};
        rows[3] = '{4'b1001, 3, 2, 4, '{0, 3, 0, 3, 0, 0, 0, 0}};
        rows[4] = '{4'b1000, 4, 2, 2, '{3, 3, 0, 0, 0, 0, 0, 0}};

        for (int p = 0; p < N; p++) begin
            p_pkt[p]  = 0;
            mo_cnt[p] = 0;
        end
        bus.m_tready = 1'b1;
        flush();

        // Reset state with nobody requesting.
        do_reset();
        cycle();
        chk("rst_m_port", s_port, 0);
        chk("rst_s_tready", s_sready, 0);
        chk("rst_m_tvalid", s_tv, 0);
        chk("rst_meta_valid", s_mv, 0);
        chk("rst_m_tdata", s_data, 0);

        // Table rows: grant order, one-cycle bubble per packet, one pulse per packet.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int k = 0; k < rows[r].rounds; k++)
                for (int p = 0; p < N; p++)
                    if (rows[r].mask[p]) push_pkt(p, rows[r].len);
            m0 = dut_mv;
            run_until_done(500, nc);
            chk($sformatf("row%0d_npkts", r), done_q.size(), rows[r].n_exp);
            for (int i = 0; i < rows[r].n_exp; i++)
                chk($sformatf("row%0d_grant%0d", r, i),
                    (i < done_q.size()) ? done_q[i] : -1, rows[r].order[i]);
            chk($sformatf("row%0d_cycles", r), nc, rows[r].n_exp * (rows[r].len + 1));
            chk($sformatf("row%0d_meta_pulses", r), dut_mv - m0, rows[r].n_exp);
            chk($sformatf("row%0d_m_port", r), s_port, rows[r].order[rows[r].n_exp-1]);
        end

        // Single-beat packet on port 1, others queue up behind it.
        do_reset();
        push_pkt(1, 1);
        cycle();
        push_pkt(0, 2);
        push_pkt(2, 2);
        push_pkt(3, 2);
        cycle();
        chk("sb_meta_valid", s_mv, 1);
        chk("sb_tlast", s_tl, 1);
        chk("sb_tvalid", s_tv, 1);
        chk("sb_s_tready", s_sready, 4'b0010);
        run_until_done(200, nc);
        chk("sb_order_n", done_q.size(), 4);
        chk("sb_order0", (done_q.size() > 0) ? done_q[0] : -1, 1);
        chk("sb_order1", (done_q.size() > 1) ? done_q[1] : -1, 2);
        chk("sb_order2", (done_q.size() > 2) ? done_q[2] : -1, 3);
        chk("sb_order3", (done_q.size() > 3) ? done_q[3] : -1, 0);

        // Port 0, 4 beats, m_tready toggling 1,0,1,0,...
        do_reset();
        tready_mode  = 1;
        bus.m_tready = 1'b1;
        push_pkt(0, 4);
        b0 = dut_beats;
        m0 = dut_mv;
        cycle();
        prev_d = '0;
        prev_m = '0;
        for (int k = 0; k < 8; k++) begin
            bus.m_tready = (k % 2) == 0;
            cycle();
            if (k > 0 && (k % 2) == 0) begin
                chk($sformatf("stall_data_k%0d", k), s_data, prev_d);
                chk($sformatf("stall_meta_k%0d", k), s_meta, prev_m);
            end
            prev_d = s_data;
            prev_m = s_meta;
        end
        chk("stall_beats", dut_beats - b0, 4);
        chk("stall_meta_pulses", dut_mv - m0, 1);
        chk("stall_pkts", done_q.size(), 1);
        tready_mode = 0;

        // Reset during beat 2 of a 4-beat packet on port 1.
        do_reset();
        push_pkt(1, 4);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        flush();
        done_q.delete();
        push_pkt(2, 2);
        push_pkt(0, 2);
        cycle();
        chk("midrst_s_tready", s_sready, 0);
        chk("midrst_m_tvalid", s_tv, 0);
        run_until_done(100, nc);
        chk("midrst_first", (done_q.size() > 0) ? done_q[0] : -1, 0);
        chk("midrst_second", (done_q.size() > 1) ? done_q[1] : -1, 2);

`ifdef PKT_STATS_EN
        // 5 packets on port 3, 2 on port 0.
        do_reset();
        for (int i = 0; i < 5; i++) push_pkt(3, 1 + (i % 3));
        push_pkt(0, 2);
        push_pkt(0, 2);
        run_until_done(200, nc);
        chk("cnt_p0", bus.pkt_cnt[0*CW +: CW], 2);
        chk("cnt_p1", bus.pkt_cnt[1*CW +: CW], 0);
        chk("cnt_p2", bus.pkt_cnt[2*CW +: CW], 0);
        chk("cnt_p3", bus.pkt_cnt[3*CW +: CW], 5);
        chk("cnt_w2_p3_wrap", bus2.pkt_cnt[3*2 +: 2], 1);
        chk("cnt_w2_p0", bus2.pkt_cnt[0*2 +: 2], 2);
`endif

        // Randomized traffic, random m_tready and pre-packet valid gaps.
        do_reset();
        gap_en      = 1'b1;
        tready_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            if (($urandom % 3) == 0) begin
                int p;
                p = int'($urandom % N);
                if (pending(p) < 4) push_pkt(p, 1 + int'($urandom % 4));
            end
            cycle();
        end
        run_until_done(3000, nc);
        gap_en      = 1'b0;
        tready_mode = 0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
